// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals around alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic [1:0] req0_ctrl;
    logic [1:0] req1_ctrl;
    logic       req0_ready;
    logic       req1_ready;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic       rsp0_ready;
    logic       rsp1_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_ctrl;
    logic       alu_en;
    logic [7:0] alu_out;
    logic       alu_valid;
    logic       busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_out, alu_valid,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        output alu_a, alu_b, alu_ctrl, alu_en, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_out, alu_valid,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        input  alu_a, alu_b, alu_ctrl, alu_en, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation
// in flight, with a WAIT timeout that returns 8'hFF flagged by rsp_err.
module alu_arbiter #(
    parameter int TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT      = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic       last_grant_r;
    logic       grant_r;
    logic       grant_s;
    logic       any_req_s;
    logic       accept_s;
    logic       capture_s;
    logic       abort_s;
    logic       rsp_ready_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_inc_s;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [1:0] alu_ctrl_r;
    logic       alu_en_r;
    logic       busy_r;
    logic       rsp0_valid_r;
    logic       rsp1_valid_r;
    logic [7:0] rsp_data_r;
    logic       rsp_err_r;

    // Returns 1 when requester 1 wins; a tie goes to whoever did not win last.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

    // Arbitration and next-state decode
    always_comb begin
        any_req_s   = bus.req0_valid | bus.req1_valid;
        grant_s     = pick_grant(bus.req0_valid, bus.req1_valid, last_grant_r);
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        abort_s     = 1'b0;
        cnt_inc_s   = cnt_r + 8'd1;
        rsp_ready_s = grant_r ? bus.rsp1_ready : bus.rsp0_ready;
        state_s     = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still counts as a normal capture
                if (bus.alu_valid) begin
                    capture_s = 1'b1;
                    state_s   = RESP;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    abort_s   = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s   = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // The accept pulse must land in the IDLE cycle itself, so it is decoded, but forced low in reset
    assign bus.req0_ready = rst & accept_s & ~grant_s;
    assign bus.req1_ready = rst & accept_s & grant_s;

    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_ctrl   = alu_ctrl_r;
    assign bus.alu_en     = alu_en_r;
    assign bus.busy       = busy_r;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_err    = rsp_err_r;

    // State, grant bookkeeping, operand latch, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            cnt_r        <= 8'd0;
            alu_a_r      <= 4'd0;
            alu_b_r      <= 4'd0;
            alu_ctrl_r   <= 2'd0;
            alu_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_data_r   <= 8'h00;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                grant_r      <= grant_s;
                last_grant_r <= grant_s;
                alu_a_r      <= grant_s ? bus.req1_a    : bus.req0_a;
                alu_b_r      <= grant_s ? bus.req1_b    : bus.req0_b;
                alu_ctrl_r   <= grant_s ? bus.req1_ctrl : bus.req0_ctrl;
            end
            if (state_r == ISSUE) begin
                cnt_r <= 8'd0;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_inc_s;
            end
            if (capture_s) begin
                rsp_data_r <= bus.alu_out;
                rsp_err_r  <= 1'b0;
            end else if (abort_s) begin
                rsp_data_r <= 8'hFF;
                rsp_err_r  <= 1'b1;
            end
            alu_en_r     <= (state_s == ISSUE) || (state_s == WAIT);
            busy_r       <= (state_s != IDLE);
            rsp0_valid_r <= (state_s == RESP) && !grant_r;
            rsp1_valid_r <= (state_s == RESP) && grant_r;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with an ALU model of
// programmable latency and a transaction-level round-robin reference.
module tb_alu_arbiter;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    alu_arbiter #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       err;
        int         lat;
        int         t;
        logic       seen;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   p0 = 0;
    int   p1 = 0;
    int   prr = 100;
    int   lat_fix = 1;
    bit   fix_ops = 1'b0;
    int   cur_lat = 0;
    int   en_cnt = 0;
    bit   model_free = 1'b1;
    logic model_last = 1'b1;
    int   n_grant = 0;
    int   n_resp = 0;
    logic [7:0] last_data = 8'h00;
    logic last_err = 1'b0;
    logic last_id = 1'b0;
    int   last_lat = 0;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
        logic [7:0] r;
        case (c)
            2'd0:    r = 8'(a) + 8'(b);
            2'd1:    r = 8'(a) - 8'(b);
            2'd2:    r = 8'(a) * 8'(b);
            default: r = {a, b};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] outs();
        return {7'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                bus.rsp_err, bus.alu_en, bus.busy, bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.rsp_data};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requesters, response consumers and the ALU model, all driven just after the rising edge
    initial begin : drive
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 4'd0; bus.req0_b = 4'd0; bus.req0_ctrl = 2'd0;
        bus.req1_a = 4'd0; bus.req1_b = 4'd0; bus.req1_ctrl = 2'd0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.req0_valid = (int'($urandom_range(100, 1)) <= p0);
            bus.req1_valid = (int'($urandom_range(100, 1)) <= p1);
            if (fix_ops) begin
                bus.req0_a = 4'd14; bus.req0_b = 4'd7; bus.req0_ctrl = 2'd0;
            end else begin
                bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_ctrl = 2'($urandom);
            end
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_ctrl = 2'($urandom);
            bus.rsp0_ready = (int'($urandom_range(100, 1)) <= prr);
            bus.rsp1_ready = (int'($urandom_range(100, 1)) <= prr);
            if (rst && bus.alu_en) en_cnt++;
            else en_cnt = 0;
            bus.alu_valid = (cur_lat != 0) && (en_cnt == cur_lat + 1);
            bus.alu_out = bus.alu_valid ? alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl) : 8'($urandom);
        end
    end

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin : monitor
        exp_t e;
        logic v0, v1, g, any;
        int   lat;
        bit   ok;
        if (!rst) begin
            sbq.delete();
            glog.delete();
            model_free = 1'b1;
            model_last = 1'b1;
        end else begin
            cyc++;
            chk("ready_excl", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
            chk("en_without_busy", {31'd0, bus.alu_en & ~bus.busy}, 32'd0);
            chk("busy", {31'd0, bus.busy}, {31'd0, ~model_free});
            if (model_free) begin
                v0 = bus.req0_valid;
                v1 = bus.req1_valid;
                any = v0 | v1;
                g = (v0 && v1) ? ~model_last : v1;
                chk("grant", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, any & g, any & ~g});
                if (any) begin
                    lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(17, 0));
                    cur_lat = lat;
                    ok = (lat >= 1) && (lat <= TMO);
                    e.id   = g;
                    e.data = !ok ? 8'hFF : (g ? alu_f(bus.req1_a, bus.req1_b, bus.req1_ctrl)
                                              : alu_f(bus.req0_a, bus.req0_b, bus.req0_ctrl));
                    e.err  = !ok;
                    e.lat  = 2 + (ok ? lat : TMO);
                    e.t    = cyc;
                    e.seen = 1'b0;
                    sbq.push_back(e);
                    glog.push_back(int'(g));
                    model_last = g;
                    model_free = 1'b0;
                    n_grant++;
                end
            end else begin
                chk("grant_while_busy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
                end else begin
                    e = sbq[0];
                    chk("rsp_channel", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, e.id ? 32'd2 : 32'd1);
                    chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                    if (!e.seen) begin
                        last_lat = cyc - e.t;
                        chk("latency", last_lat, e.lat);
                        e.seen = 1'b1;
                        sbq[0] = e;
                    end
                    if (e.id ? bus.rsp1_ready : bus.rsp0_ready) begin
                        last_data = bus.rsp_data;
                        last_err  = bus.rsp_err;
                        last_id   = e.id;
                        void'(sbq.pop_front());
                        model_free = 1'b1;
                        n_resp++;
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].seen) begin
                chk("rsp_dropped", 32'd0, 32'd1);
            end
        end
    end

    task automatic wait_grant(input int g0, input string name);
        int k = 0;
        while (n_grant == g0 && k < 60) begin @(negedge clk); #2; k++; end
        chk(name, {31'd0, n_grant > g0}, 32'd1);
    endtask

    task automatic wait_resp(input int target, input string name);
        int k = 0;
        while (n_resp < target && k < 100) begin @(negedge clk); #2; k++; end
        chk(name, {31'd0, n_resp >= target}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!model_free && k < 100) begin @(negedge clk); #2; k++; end
        chk(name, {31'd0, model_free}, 32'd1);
    endtask

    task automatic one_op(input int req, input int lat, input string name);
        int g0 = n_grant;
        int r0 = n_resp;
        lat_fix = lat;
        prr = 100;
        if (req == 0) p0 = 100;
        else p1 = 100;
        wait_grant(g0, {name, "_accept"});
        p0 = 0;
        p1 = 0;
        wait_resp(r0 + 1, {name, "_resp"});
    endtask

    initial begin : main
        int k;
        rst = 1'b0;
        #12;
        chk("reset_outputs", outs(), 32'd0);
        @(negedge clk); #2;
        rst = 1'b1;

        // Both requesters always valid: strict alternation starting with 0
        lat_fix = 1; prr = 100; p0 = 100; p1 = 100;
        k = 0;
        while (n_grant < 4 && k < 100) begin @(negedge clk); #2; k++; end
        p0 = 0; p1 = 0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_grant%0d", i), (i < glog.size()) ? glog[i] : -1, i % 2);
        wait_idle("alt_drain");

        fix_ops = 1'b1;
        one_op(0, 1, "basic");
        fix_ops = 1'b0;
        chk("basic_data", {24'd0, last_data}, 32'h15);
        chk("basic_err", {31'd0, last_err}, 32'd0);
        chk("basic_id", {31'd0, last_id}, 32'd0);
        chk("basic_latency", last_lat, 3);

        one_op(0, 0, "timeout");
        chk("timeout_data", {24'd0, last_data}, 32'hFF);
        chk("timeout_err", {31'd0, last_err}, 32'd1);
        chk("timeout_latency", last_lat, 2 + TMO);
        one_op(1, TMO, "late_valid");
        chk("late_err", {31'd0, last_err}, 32'd0);
        chk("late_id", {31'd0, last_id}, 32'd1);
        chk("late_latency", last_lat, 2 + TMO);

        // Stalled response: held stable, req1 kept waiting
        lat_fix = 1; prr = 0; p0 = 100;
        k = 0;
        while (!bus.rsp0_valid && k < 50) begin @(negedge clk); #2; k++; end
        p0 = 0; p1 = 100;
        k = n_resp;
        repeat (5) begin
            @(negedge clk); #2;
            chk("hold_valid", {31'd0, bus.rsp0_valid}, 32'd1);
            chk("hold_busy", {31'd0, bus.busy}, 32'd1);
            chk("hold_no_req1", {31'd0, bus.req1_ready}, 32'd0);
        end
        prr = 100;
        wait_resp(k + 1, "hold_release");
        wait_grant(n_grant - 1 + ((glog.size() > 0 && glog[glog.size() - 1] == 1) ? 0 : 1), "hold_req1_next");
        p1 = 0;
        wait_idle("hold_drain");

        // Asynchronous reset while waiting on the ALU
        lat_fix = 0; p0 = 100; p1 = 100;
        k = 0;
        while (!bus.alu_en && k < 50) begin @(negedge clk); #2; k++; end
        p0 = 0; p1 = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("in_wait_before_reset", {31'd0, bus.alu_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        lat_fix = 1; p0 = 100; p1 = 100;
        k = 0;
        while (glog.size() == 0 && k < 20) begin @(negedge clk); #2; k++; end
        p0 = 0; p1 = 0;
        chk("post_reset_grant", (glog.size() > 0) ? glog[0] : -1, 0);
        wait_idle("post_reset_drain");

        // Randomised traffic with random latencies and back-pressure
        lat_fix = -1; p0 = 45; p1 = 45; prr = 60;
        repeat (800) @(negedge clk);
        #2;
        p0 = 0; p1 = 0; prr = 100;
        wait_idle("random_drain");
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog expired");
    end
endmodule
